// File: rtl/mac_accumulator.sv
// Sums LEN consecutive 6-bit unsigned products into one ACC_W-bit result and
// offers it over valid/ready. Define MAC_SAT_EN to clamp on overflow and flag it.
module mac_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN   = 8,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [5:0]       prod_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    output logic [ACC_W-1:0] res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             res_sat_o,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds with stable data until that edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W-1:0]   w_add;
    logic               w_accept;
    logic               w_last;

    assign w_accept  = prod_valid_i & prod_ready_o;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(LEN));

`ifdef MAC_SAT_EN
    logic [ACC_W:0] w_sum;
    logic           w_clamp;
    logic           r_sat;

    assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(prod_i);
    assign w_clamp = w_sum[ACC_W];
    assign w_add   = w_clamp ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_add   = r_acc + ACC_W'(prod_i);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next = (LEN == 1) ? S_HOLD : S_ACCUM;
                S_ACCUM: if (w_accept && w_last) w_next = S_HOLD;
                S_HOLD:  if (res_ready_i) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        prod_ready_o = (r_state != S_HOLD);
        res_valid_o  = (r_state == S_HOLD);
        dbg_state_o  = r_state;
    end

    // The accumulator doubles as the result register; it is frozen while in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_acc <= ACC_W'(prod_i);
                    r_cnt <= CNT_W'(1);
                end
                S_ACCUM: if (w_accept) begin
                    r_acc <= w_add;
                    r_cnt <= w_cnt_inc;
                end
                S_HOLD: if (res_ready_i) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                default: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

`ifdef MAC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (clr_i) begin
            r_sat <= 1'b0;
        end else if (r_state == S_ACCUM && w_accept && w_clamp) begin
            r_sat <= 1'b1;
        end else if (r_state == S_HOLD && res_ready_i) begin
            r_sat <= 1'b0;
        end
    end

    assign res_sat_o = r_sat;
`else
    assign res_sat_o = 1'b0;
`endif

    assign res_o = r_acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: three instances (LEN=4, ACC_W=8/LEN=8, LEN=1)
// driven by directed vectors; a negedge monitor pops expected results on each handshake.
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clr        [3];
    logic [5:0]  prod       [3];
    logic        prod_valid [3];
    logic        prod_ready [3];
    logic        res_valid  [3];
    logic        res_ready  [3];
    logic        res_sat    [3];
    logic [1:0]  dbg        [3];
    logic [15:0] res0;
    logic [7:0]  res1;
    logic [15:0] res2;

    logic [16:0] exp_q0[$];
    logic [16:0] exp_q1[$];
    logic [16:0] exp_q2[$];

    int n_tests = 0;
    int n_fail  = 0;
    int low_cnt2 = 0;

    mac_accumulator #(.ACC_W(16), .LEN(4)) u_len4 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr[0]), .prod_i(prod[0]),
        .prod_valid_i(prod_valid[0]), .prod_ready_o(prod_ready[0]), .res_o(res0),
        .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]), .res_sat_o(res_sat[0]),
        .dbg_state_o(dbg[0])
    );

    mac_accumulator #(.ACC_W(8), .LEN(8)) u_len8 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr[1]), .prod_i(prod[1]),
        .prod_valid_i(prod_valid[1]), .prod_ready_o(prod_ready[1]), .res_o(res1),
        .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]), .res_sat_o(res_sat[1]),
        .dbg_state_o(dbg[1])
    );

    mac_accumulator #(.ACC_W(16), .LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr[2]), .prod_i(prod[2]),
        .prod_valid_i(prod_valid[2]), .prod_ready_o(prod_ready[2]), .res_o(res2),
        .res_valid_o(res_valid[2]), .res_ready_i(res_ready[2]), .res_sat_o(res_sat[2]),
        .dbg_state_o(dbg[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] res_of(int d);
        case (d)
            0:       return res0;
            1:       return {8'd0, res1};
            default: return res2;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic sat, input logic [15:0] val);
        case (d)
            0:       exp_q0.push_back({sat, val});
            1:       exp_q1.push_back({sat, val});
            default: exp_q2.push_back({sat, val});
        endcase
    endtask

    task automatic pop_cmp(input int d);
        logic [16:0] e;
        int sz;
        case (d)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result dut%0d: got %0d, expected none", d, res_of(d));
        end else begin
            case (d)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check($sformatf("res dut%0d", d), 32'(res_of(d)), 32'(e[15:0]));
            check($sformatf("sat dut%0d", d), 32'(res_sat[d]), 32'(e[16]));
        end
    endtask

    // Monitor: a result leaves on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (res_valid[d] && res_ready[d] && !clr[d]) pop_cmp(d);
            end
            if (!prod_ready[2]) low_cnt2++;
        end
    end

    task automatic send(input int d, input logic [5:0] p);
        int n;
        prod_valid[d] = 1'b1;
        prod[d] = p;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prod_ready[d] && n < 50);
        if (!prod_ready[d]) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout dut%0d: got ready=0, expected ready=1", d);
        end
        @(posedge clk);
        #1;
        prod_valid[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [5:0]  vec3 [4];
    logic [5:0]  vec7 [4];
    logic [15:0] held;
    int          budget;

    initial begin
        vec3 = '{6'd1, 6'd2, 6'd3, 6'd4};
        vec7 = '{6'd63, 6'd0, 6'd17, 6'd42};
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            clr[d] = 1'b0;
            prod[d] = 6'd0;
            prod_valid[d] = 1'b0;
            res_ready[d] = 1'b1;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst res_valid dut%0d", d), 32'(res_valid[d]), 0);
            check($sformatf("rst res dut%0d", d), 32'(res_of(d)), 0);
            check($sformatf("rst sat dut%0d", d), 32'(res_sat[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int d = 0; d < 3; d++)
            check($sformatf("rst prod_ready dut%0d", d), 32'(prod_ready[d]), 1);

        // Four products of 49; result visible the cycle after the fourth accept.
        push_exp(0, 1'b0, 16'd196);
        repeat (3) send(0, 6'd49);
        check("len4 valid before last", 32'(res_valid[0]), 0);
        send(0, 6'd49);
        check("len4 latency valid", 32'(res_valid[0]), 1);
        idle(2);

        // Backpressure: five cycles held in HOLD, accepted on the sixth.
        res_ready[0] = 1'b0;
        push_exp(0, 1'b0, 16'd100);
        send(0, 6'd10); send(0, 6'd20); send(0, 6'd30); send(0, 6'd40);
        held = res0;
        check("hold res value", 32'(held), 100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold valid", 32'(res_valid[0]), 1);
            check("hold res stable", 32'(res0), 32'(held));
            check("hold prod_ready", 32'(prod_ready[0]), 0);
        end
        @(posedge clk);
        #1;
        res_ready[0] = 1'b1;
        idle(1);
        check("after hs valid", 32'(res_valid[0]), 0);
        check("after hs prod_ready", 32'(prod_ready[0]), 1);
        check("after hs res", 32'(res0), 0);

        // Gaps of 0-3 idle cycles between products.
        push_exp(0, 1'b0, 16'd10);
        for (int i = 0; i < 4; i++) begin
            send(0, vec3[i]);
            if (i < 3) begin
                idle($urandom_range(0, 3));
                check("gap no early valid", 32'(res_valid[0]), 0);
            end
        end
        idle(2);

        // Clear mid-accumulation drops the partial sum and the concurrent product.
        send(0, 6'd9); send(0, 6'd9);
        clr[0] = 1'b1;
        prod_valid[0] = 1'b1;
        prod[0] = 6'd9;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        prod_valid[0] = 1'b0;
        check("clr state idle", 32'(dbg[0]), 0);
        check("clr res", 32'(res0), 0);
        push_exp(0, 1'b0, 16'd4);
        repeat (4) send(0, 6'd1);
        idle(2);

        // ACC_W=8 overflow: 8 x 49 = 392.
`ifdef MAC_SAT_EN
        push_exp(1, 1'b1, 16'd255);
`else
        push_exp(1, 1'b0, 16'd136);
`endif
        repeat (8) send(1, 6'd49);
        idle(2);

        // Async reset mid-accumulation (cnt=2).
        send(0, 6'd5); send(0, 6'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(res_valid[0]), 0);
        check("async rst res", 32'(res0), 0);
        check("async rst state", 32'(dbg[0]), 0);
        #2;
        rst_n = 1'b1;
        idle(1);
        push_exp(0, 1'b0, 16'd28);
        repeat (4) send(0, 6'd7);
        idle(2);

        // LEN=1: result every accept, prod_ready low one cycle per result.
        low_cnt2 = 0;
        for (int i = 0; i < 4; i++) begin
            push_exp(2, 1'b0, 16'(vec7[i]));
            send(2, vec7[i]);
            check("len1 latency valid", 32'(res_valid[2]), 1);
        end
        idle(1);
        check("len1 ready low cycles", 32'(low_cnt2), 4);

        budget = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        check("drain q0", 32'(exp_q0.size()), 0);
        check("drain q1", 32'(exp_q1.size()), 0);
        check("drain q2", 32'(exp_q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
